// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - arb_state_e : FSM state encoding (IDLE, I_BUSY, D_BUSY, RESP)
//   - SIZE_BYTE / SIZE_HALF / SIZE_WORD : access size codes on d_size/mem_size
//   - TIMEOUT_CYCLES_DEFAULT : default BUSY wait limit for the timeout build
//   - mem_cmd_t : the request latched when a requester is granted
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Counts BUSY cycles that pass without a memory acknowledge.
// Ports:
//   clock   : clock, rising-edge
//   reset   : asynchronous active-high reset, count -> 0
//   clear   : synchronous clear (held while the arbiter is not BUSY)
//   enable  : count one more BUSY cycle without ack
//   expired : count has reached TIMEOUT_CYCLES-1, i.e. this is the last
//             BUSY cycle the arbiter is allowed to wait
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Largest value ever held is TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates one shared memory port between an instruction-fetch requester
// and a data (load/store) requester. Data has fixed priority. Requests are
// sampled only in IDLE; the winner's command is latched and presented on
// mem_* until mem_ack, then the granted side gets a one-cycle ready pulse
// (RESP state) and the FSM returns to IDLE.
//
// Parameters:
//   TIMEOUT_CYCLES : max BUSY cycles to wait for mem_ack (timeout build only)
// Build option:
//   MEM_ARB_TIMEOUT_EN : when defined, a BUSY access with no ack after
//                        TIMEOUT_CYCLES cycles is aborted with ready+err and
//                        rdata forced to 0. When undefined, BUSY waits forever
//                        and err is constant 0.
// Ports:
//   clock, reset                  : clock and asynchronous active-high reset
//   if_req/if_addr                : fetch request in
//   if_rdata/if_ready             : fetch data and completion pulse out
//   d_req/d_we/d_addr/d_wdata/d_size : data request in
//   d_rdata/d_ready               : load data and completion pulse out
//   mem_req/mem_we/mem_addr/mem_wdata/mem_size : memory command out
//   mem_rdata/mem_ack             : memory response in
//   stall_if, stall_mem           : combinational stall indications
//   err                           : timeout pulse, aligned with ready
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  // instruction fetch side
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // status
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  arb_state_e  state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;

  logic busy;
  logic timeout_hit;

  assign busy = (state_q == I_BUSY) || (state_q == D_BUSY);

`ifdef MEM_ARB_TIMEOUT_EN
  logic timer_expired;
  logic err_q;

  // Held clear outside BUSY so every BUSY entry starts from zero.
  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (~busy),
    .enable  (busy & ~mem_ack),
    .expired (timer_expired)
  );

  // A real ack in the final allowed cycle still wins over the timeout.
  assign timeout_hit = busy & ~mem_ack & timer_expired;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  // The wait limit has no meaning without the timeout build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err                = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          cmd_d.we    = d_we;
          cmd_d.addr  = d_addr;
          cmd_d.wdata = d_wdata;
          cmd_d.size  = d_size;
          state_d     = D_BUSY;
        end else if (if_req) begin
          cmd_d.we    = 1'b0;
          cmd_d.addr  = if_addr;
          cmd_d.wdata = '0;
          cmd_d.size  = SIZE_WORD;
          state_d     = I_BUSY;
        end
      end

      I_BUSY: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          state_d    = RESP;
        end else if (timeout_hit) begin
          if_rdata_d = '0;
          if_ready_d = 1'b1;
          state_d    = RESP;
        end
      end

      D_BUSY: begin
        if (mem_ack) begin
          // Stores complete without touching the load data register.
          if (!cmd_q.we) begin
            d_rdata_d = mem_rdata;
          end
          d_ready_d = 1'b1;
          state_d   = RESP;
        end else if (timeout_hit) begin
          d_rdata_d = '0;
          d_ready_d = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  // Memory command is decoded straight from state and latched command so
  // that an asynchronous reset removes mem_req without waiting for a clock.
  assign mem_req   = busy;
  assign mem_we    = busy & cmd_q.we;
  assign mem_addr  = busy ? cmd_q.addr  : '0;
  assign mem_wdata = busy ? cmd_q.wdata : '0;
  assign mem_size  = busy ? cmd_q.size  : '0;

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;

  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUSY cycles to wait for mem_ack (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch read data.
- if_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data-access request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_size  in  2  00 byte, 01 half, 10 word.
- d_rdata  out  32  load read data.
- d_ready  out  1  one-cycle data completion pulse.
- mem_req  out  1  request to the shared memory.
- mem_we  out  1  write enable.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_size  out  2  access size.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.
- stall_if  out  1  combinational: if_req & ~if_ready.
- stall_mem  out  1  combinational: d_req & ~d_ready.
- err  out  1  one-cycle timeout pulse, aligned with the aborted ready.

Function
REQ-003 SHALL implement an FSM with states IDLE, I_BUSY, D_BUSY and RESP.
REQ-004 SHALL sample if_req and d_req only in IDLE, never in BUSY or RESP.
REQ-005 In IDLE, d_req=1 SHALL win over if_req (fixed data priority); the winner's addr/we/wdata/size SHALL be latched internally at that edge and the FSM SHALL go to D_BUSY or I_BUSY.
REQ-006 In I_BUSY/D_BUSY, mem_req SHALL be 1 with mem_* driven from the latched values; a fetch SHALL drive mem_we=0 and mem_size=10.
REQ-007 mem_req SHALL be 0 in IDLE and RESP, and all mem_* outputs SHALL be 0 whenever mem_req=0.
REQ-008 When mem_ack=1 in a BUSY state: mem_rdata SHALL be registered into the granted side's rdata (stores leave d_rdata unchanged), the FSM SHALL go to RESP, and that side's ready SHALL be 1 for exactly the RESP cycle.
REQ-009 RESP SHALL go to IDLE unconditionally; a requester still asserting req in the cycle after ready is treated as a new transaction.
REQ-010 Minimum latency SHALL be: req sampled at edge N, mem_req=1 in cycle N+1, ack in cycle N+1, ready in cycle N+2.
REQ-011 if_rdata and d_rdata SHALL hold their last value until overwritten.
REQ-012 mem_ack received in IDLE or RESP SHALL be ignored and cause no state or output change.
REQ-013 if_ready and d_ready SHALL never be 1 in the same cycle.

Reset
REQ-014 Reset SHALL asynchronously force state IDLE, all outputs 0, the latched request 0, and the timeout counter 0.
REQ-015 Reset asserted mid-transaction SHALL drop mem_req immediately, with no ready pulse for the aborted request.

Configuration
REQ-016 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; at count TIMEOUT_CYCLES-1 with no ack, the FSM SHALL go to RESP with ready=1, err=1 and the granted rdata set to 0.
REQ-017 Without MEM_ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely, err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state encoding, the SIZE_BYTE/HALF/WORD constants and the default TIMEOUT_CYCLES.
REQ-019 The timeout counter SHALL be a sub-module mem_arb_timer (inputs clear, enable; output expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single fetch: if_req, if_addr=0x100, ack in 2nd BUSY cycle with rdata=0x00500093 -> if_ready pulses once, if_rdata=0x00500093, stall_if high until then.
- Collision: if_req and d_req together (load 0x2000) -> data served first, then fetch; d_ready precedes if_ready by >=2 cycles.
- Store: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_size=00 -> mem_we=1, mem_size=00, mem_wdata=0xDEADBEEF, d_rdata unchanged.
- Reset during D_BUSY -> mem_req=0 same cycle, no d_ready, FSM in IDLE.
- Spurious mem_ack in IDLE -> no ready, no state change.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> d_ready and err pulse after 4 BUSY cycles, d_rdata=0.
